// File: rtl/pc_redirect_unit.sv
// Fetch PC sequencer with predict-not-taken redirect, halt hold and a saturating
// redirect counter. All outputs are decoded from registered state.
module pc_redirect_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic [3:0] insLen,
  input  logic       haltF,
  input  logic       jmpFlag,
  input  logic [7:0] jmpTarget,
  output logic [7:0] pc,
  output logic       fetchValid,
  output logic       flushD,
  output logic       flushE,
  output logic [7:0] redirCount,
  output logic       halted
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    REDIR = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t     state, stateNext;
  logic [7:0] pcNext;
  logic [7:0] redirCountNext;

  // A zero length is treated as one byte so sequential fetch can never stick.
  function automatic logic [7:0] nextSeqPc(input logic [7:0] cur, input logic [3:0] len);
    logic [7:0] step;
    step = (len == 4'd0) ? 8'd1 : {4'd0, len};
    return cur + step;
  endfunction

  function automatic logic [7:0] satInc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;
  endfunction

  always_comb begin
    stateNext      = state;
    pcNext         = pc;
    redirCountNext = redirCount;
    case (state)
      RUN: begin
        if (jmpFlag) begin
          pcNext         = jmpTarget;
          stateNext      = REDIR;
          redirCountNext = satInc(redirCount);
        end else if (stall) begin
          stateNext = RUN;
        end else if (haltF) begin
          stateNext = HALT;
        end else begin
          pcNext = nextSeqPc(pc, insLen);
        end
      end
      REDIR: begin
        stateNext = RUN;
      end
      HALT: begin
        // A jump resolving while halted means the halt was on the wrong path.
        if (jmpFlag) begin
          pcNext         = jmpTarget;
          stateNext      = REDIR;
          redirCountNext = satInc(redirCount);
        end
      end
      default: begin
        stateNext = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      pc         <= 8'h00;
      redirCount <= 8'h00;
    end else begin
      state      <= stateNext;
      pc         <= pcNext;
      redirCount <= redirCountNext;
    end
  end

  assign fetchValid = (state == RUN);
  assign flushD     = (state == REDIR);
  assign flushE     = (state == REDIR);
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: sequential fetch, wrap, redirect priority,
// halt recovery, counter saturation and asynchronous reset during a redirect.
module tb_pc_redirect_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic [3:0] insLen;
  logic       haltF;
  logic       jmpFlag;
  logic [7:0] jmpTarget;
  logic [7:0] pc;
  logic       fetchValid;
  logic       flushD;
  logic       flushE;
  logic [7:0] redirCount;
  logic       halted;

  int errors = 0;
  int checks = 0;
  int expCnt;

  pc_redirect_unit dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .insLen    (insLen),
    .haltF     (haltF),
    .jmpFlag   (jmpFlag),
    .jmpTarget (jmpTarget),
    .pc        (pc),
    .fetchValid(fetchValid),
    .flushD    (flushD),
    .flushE    (flushE),
    .redirCount(redirCount),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    jmpFlag = 1'b0;
    stall   = 1'b0;
    haltF   = 1'b0;
  endtask

  // Redirect from RUN to tgt and return to RUN at tgt.
  task automatic goTo(input logic [7:0] tgt);
    jmpFlag   = 1'b1;
    jmpTarget = tgt;
    step();
    idle();
    step();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; insLen = 4'd1; haltF = 1'b0;
    jmpFlag = 1'b0; jmpTarget = 8'h00;
    step();
    step();
    chk("rst_pc", pc, 8'h00);
    chk("rst_cnt", redirCount, 8'h00);
    chk("rst_fv", {7'd0, fetchValid}, 8'd1);
    chk("rst_flushD", {7'd0, flushD}, 8'd0);
    chk("rst_flushE", {7'd0, flushE}, 8'd0);
    chk("rst_halted", {7'd0, halted}, 8'd0);
    rst = 1'b0;

    // Sequential fetch
    insLen = 4'd2;  step(); chk("seq_pc02", pc, 8'h02);
    insLen = 4'd10; step(); chk("seq_pc0C", pc, 8'h0C);
    insLen = 4'd1;  step(); chk("seq_pc0D", pc, 8'h0D);
    chk("seq_fv", {7'd0, fetchValid}, 8'd1);

    // Wrap and zero length
    goTo(8'hFE);
    chk("wrap_start", pc, 8'hFE);
    insLen = 4'd3; step(); chk("wrap_pc01", pc, 8'h01);
    insLen = 4'd0; step(); chk("zero_len_pc02", pc, 8'h02);

    // Redirect wins over stall and halt; REDIR ignores all inputs
    goTo(8'h10);
    chk("pri_start", pc, 8'h10);
    jmpFlag = 1'b1; jmpTarget = 8'h40; stall = 1'b1; haltF = 1'b1; insLen = 4'd4;
    step();
    chk("pri_pc", pc, 8'h40);
    chk("pri_fv", {7'd0, fetchValid}, 8'd0);
    chk("pri_flushD", {7'd0, flushD}, 8'd1);
    chk("pri_flushE", {7'd0, flushE}, 8'd1);
    chk("pri_cnt", redirCount, 8'd3);
    jmpTarget = 8'h77;
    step();
    chk("redir_ign_pc", pc, 8'h40);
    chk("redir_ign_fv", {7'd0, fetchValid}, 8'd1);
    chk("redir_ign_cnt", redirCount, 8'd3);
    chk("redir_ign_flushD", {7'd0, flushD}, 8'd0);

    // Stall holds pc while fetch stays valid
    idle(); stall = 1'b1; insLen = 4'd5;
    step();
    chk("stall_pc", pc, 8'h40);
    chk("stall_fv", {7'd0, fetchValid}, 8'd1);
    idle();

    // Halt then wrong-path recovery
    goTo(8'h20);
    haltF = 1'b1; insLen = 4'd3;
    step();
    chk("halt_halted", {7'd0, halted}, 8'd1);
    chk("halt_fv", {7'd0, fetchValid}, 8'd0);
    for (int i = 0; i < 5; i++) begin
      haltF = i[0];
      stall = ~i[0];
      step();
      chk("halt_hold_pc", pc, 8'h20);
      chk("halt_hold_h", {7'd0, halted}, 8'd1);
    end
    idle(); jmpFlag = 1'b1; jmpTarget = 8'h30;
    step();
    chk("hrec_pc", pc, 8'h30);
    chk("hrec_flushD", {7'd0, flushD}, 8'd1);
    chk("hrec_halted", {7'd0, halted}, 8'd0);
    chk("hrec_cnt", redirCount, 8'd5);
    idle();
    step();
    chk("hrec_run_pc", pc, 8'h30);
    chk("hrec_run_fv", {7'd0, fetchValid}, 8'd1);
    chk("hrec_run_h", {7'd0, halted}, 8'd0);

    // Redirect to the current pc
    jmpFlag = 1'b1; jmpTarget = 8'h30;
    step();
    chk("self_pc", pc, 8'h30);
    chk("self_flushE", {7'd0, flushE}, 8'd1);
    chk("self_cnt", redirCount, 8'd6);
    idle();
    step();
    chk("self_fv", {7'd0, fetchValid}, 8'd1);

    // Saturation over 300 redirects
    expCnt = 6;
    insLen = 4'd1;
    for (int i = 0; i < 300; i++) begin
      jmpFlag = 1'b1; jmpTarget = 8'(i);
      step();
      jmpFlag = 1'b0;
      step();
      expCnt = (expCnt < 255) ? expCnt + 1 : 255;
      chk("sat_cnt", redirCount, 8'(expCnt));
    end
    chk("sat_final", redirCount, 8'hFF);

    // Asynchronous reset in the REDIR cycle
    jmpFlag = 1'b1; jmpTarget = 8'h55;
    step();
    chk("ar_redir_flushD", {7'd0, flushD}, 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_flushD", {7'd0, flushD}, 8'd0);
    chk("ar_flushE", {7'd0, flushE}, 8'd0);
    chk("ar_pc", pc, 8'h00);
    chk("ar_cnt", redirCount, 8'h00);
    chk("ar_fv", {7'd0, fetchValid}, 8'd1);
    idle(); insLen = 4'd4;
    step();
    rst = 1'b0;
    #1;
    chk("ar_rel_flushD", {7'd0, flushD}, 8'd0);
    step();
    chk("ar_resume_pc", pc, 8'h04);
    chk("ar_resume_fv", {7'd0, fetchValid}, 8'd1);
    chk("ar_resume_flushE", {7'd0, flushE}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
